// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: opcodes, access-width codes, FSM state type and address-offset helpers.
package mem_access_unit_pkg;
  localparam logic [6:0] OPCODE_LOAD  = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE = 7'b0100011;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  // Lane offset actually used: misaligned H/W fall back to their naturally aligned lane.
  function automatic logic [1:0] eff_off(logic [2:0] f3, logic [1:0] off);
    return f3[1:0] == F3_W[1:0] ? 2'b00 : f3[1:0] == F3_H[1:0] ? {off[1], 1'b0} : off;
  endfunction
  function automatic logic misaligned(logic [2:0] f3, logic [1:0] off);
    return (f3[1:0] == F3_H[1:0] && off[0]) || (f3[1:0] == F3_W[1:0] && off != 2'b00);
  endfunction
endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: data-memory request/response bus; master is the access unit, slave the memory.
interface mem_access_unit_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );
  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/mem_access_unit_lsu_align.sv
// lsu_align: store byte-enable/lane replication and load lane extract with sign/zero extension.
module lsu_align
  import mem_access_unit_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [1:0]  off,
  input  logic [31:0] st_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ld_data
);
  logic [31:0] shifted;
  logic        sx;
  logic        is_w;
  logic        is_h;
  always_comb begin
    is_w    = func3[1:0] == F3_W[1:0];
    is_h    = func3[1:0] == F3_H[1:0];
    sx      = func3 != F3_BU && func3 != F3_HU;
    shifted = rdata >> {off, 3'b000};
    be      = is_w ? 4'b1111 : is_h ? 4'b0011 << off : 4'b0001 << off;
    wdata   = is_w ? st_data : is_h ? {2{st_data[15:0]}} : {4{st_data[7:0]}};
    ld_data = is_w ? shifted
            : is_h ? {{16{sx & shifted[15]}}, shifted[15:0]}
            : {{24{sx & shifted[7]}}, shifted[7:0]};
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: memory stage issuing one load/store at a time on the dmem bus and driving writeback.
// Optional MISALIGN_TRAP_EN: misaligned H/W accesses raise misalign_exc instead of being aligned down.
module mem_access_unit
  import mem_access_unit_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ex_valid,
  input  logic [6:0]         opcode,
  input  logic [2:0]         func3,
  input  logic [31:0]        alu_result,
  input  logic [31:0]        store_data,
  input  logic [4:0]         rd_in,
  output logic               stall,
  mem_access_unit_if.master  bus,
  output logic               wb_valid,
  output logic [31:0]        wb_data,
  output logic [4:0]         wb_rd
`ifdef MISALIGN_TRAP_EN
  ,
  output logic               misalign_exc
`endif
);
  state_t      state;
  state_t      state_nxt;
  logic        is_mem;
  logic        alu_wb;
  logic        trap;
  logic        start;
  logic        ld_done;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [4:0]  rd_q;
  logic [2:0]  al_f3;
  logic [1:0]  al_off;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_ld;

  assign is_mem = opcode == OPCODE_LOAD || opcode == OPCODE_STORE;
  assign alu_wb = state == IDLE && ex_valid && !is_mem;
`ifdef MISALIGN_TRAP_EN
  assign trap = rst_n && state == IDLE && ex_valid && is_mem && misaligned(func3, alu_result[1:0]);
`else
  assign trap = 1'b0;
`endif
  // rst_n gates the combinational start so stall stays low throughout reset.
  assign start   = rst_n && state == IDLE && ex_valid && is_mem && !trap;
  assign stall   = start || state == REQ || state == WAIT;
  assign ld_done = bus.dmem_rvalid && !we_q && (state == WAIT || (state == REQ && bus.dmem_gnt));

  // The aligner serves the incoming op in IDLE and the latched access afterwards.
  assign al_f3  = state == IDLE ? func3 : f3_q;
  assign al_off = state == IDLE ? eff_off(func3, alu_result[1:0]) : off_q;

  lsu_align u_align (
    .func3   (al_f3),
    .off     (al_off),
    .st_data (store_data),
    .rdata   (bus.dmem_rdata),
    .be      (al_be),
    .wdata   (al_wdata),
    .ld_data (al_ld)
  );

  assign bus.dmem_req   = state == REQ;
  assign bus.dmem_we    = state == REQ && we_q;
  assign bus.dmem_addr  = addr_q;
  assign bus.dmem_wdata = wdata_q;
  assign bus.dmem_be    = be_q;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = start ? REQ : IDLE;
      REQ:  state_nxt = !bus.dmem_gnt ? REQ : (we_q || bus.dmem_rvalid) ? DONE : WAIT;
      WAIT: state_nxt = bus.dmem_rvalid ? DONE : WAIT;
      DONE: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      we_q     <= 1'b0;
      f3_q     <= '0;
      off_q    <= '0;
      rd_q     <= '0;
      wb_valid <= 1'b0;
      wb_data  <= '0;
      wb_rd    <= '0;
`ifdef MISALIGN_TRAP_EN
      misalign_exc <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (start) begin
        addr_q  <= {alu_result[31:2], 2'b00};
        off_q   <= al_off;
        wdata_q <= al_wdata;
        be_q    <= al_be;
        we_q    <= opcode == OPCODE_STORE;
        f3_q    <= func3;
        rd_q    <= rd_in;
      end
      wb_valid <= alu_wb || ld_done;
      if (alu_wb) begin
        wb_data <= alu_result;
        wb_rd   <= rd_in;
      end else if (ld_done) begin
        wb_data <= al_ld;
        wb_rd   <= rd_q;
      end
`ifdef MISALIGN_TRAP_EN
      misalign_exc <= trap;
`endif
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scenario tasks with a writeback scoreboard; define MISALIGN_TRAP_EN to cover the trap build.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;
  localparam logic [6:0] OP_ALU = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic [6:0]  opcode = '0;
  logic [2:0]  func3 = '0;
  logic [31:0] alu_result = '0;
  logic [31:0] store_data = '0;
  logic [4:0]  rd_in = '0;
  logic        stall;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
`ifdef MISALIGN_TRAP_EN
  logic        misalign_exc;
`endif
  int          vectors = 0;
  int          errors = 0;
  logic [36:0] exp_q[$];
  logic [36:0] mon_e;

  mem_access_unit_if bus ();

  mem_access_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ex_valid   (ex_valid),
    .opcode     (opcode),
    .func3      (func3),
    .alu_result (alu_result),
    .store_data (store_data),
    .rd_in      (rd_in),
    .stall      (stall),
    .bus        (bus),
    .wb_valid   (wb_valid),
    .wb_data    (wb_data),
    .wb_rd      (wb_rd)
`ifdef MISALIGN_TRAP_EN
    ,
    .misalign_exc (misalign_exc)
`endif
  );

  always #5 clk = ~clk;

  // Scoreboard: every writeback must match the oldest expected {data, rd}.
  always @(negedge clk) begin
    if (wb_valid) begin
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected: wb_data=%h wb_rd=%0d, required no writeback", wb_data, wb_rd);
      end else begin
        mon_e = exp_q.pop_front();
        if ({wb_data, wb_rd} !== mon_e) begin
          errors++;
          $display("FAIL wb_data: got %h rd %0d, required %h rd %0d", wb_data, wb_rd, mon_e[36:5], mon_e[4:0]);
        end
      end
    end
  end

  task automatic mem_op(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] data, input logic [4:0] rd, input int gnt_k, input int rv_k,
                        input logic [31:0] rdata, output logic [31:0] o_addr, output logic [31:0] o_wdata,
                        output logic [3:0] o_be, output logic o_we, output int n_stall, output logic o_stable);
    logic seen;
    seen = 1'b0;
    o_stable = 1'b1;
    n_stall = 0;
    {o_addr, o_wdata, o_be, o_we} = '0;
    @(negedge clk);
    opcode = op; func3 = f3; alu_result = addr; store_data = data; rd_in = rd; ex_valid = 1'b1;
    bus.dmem_rdata = rdata;
    #1 if (stall) n_stall++;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (!stall) begin
        ex_valid = 1'b0; bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b0;
        return;
      end
      n_stall++;
      if (bus.dmem_req) begin
        if (seen && {o_addr, o_wdata, o_be, o_we} !== {bus.dmem_addr, bus.dmem_wdata, bus.dmem_be, bus.dmem_we})
          o_stable = 1'b0;
        if (!seen) {o_addr, o_wdata, o_be, o_we} = {bus.dmem_addr, bus.dmem_wdata, bus.dmem_be, bus.dmem_we};
        seen = 1'b1;
      end
      bus.dmem_gnt = k == gnt_k;
      bus.dmem_rvalid = op == OPCODE_LOAD && k == gnt_k + rv_k;
    end
    vectors++; errors++;
    $display("FAIL mem_op_timeout: stall=%b after 30 cycles, required 0", stall);
    ex_valid = 1'b0; bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    opcode = OPCODE_LOAD; func3 = F3_W; alu_result = 32'h40; ex_valid = 1'b1;
    #1;
    vectors++;
    if ({stall, bus.dmem_req, bus.dmem_we, wb_valid} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl: stall/req/we/wb=%b, required 0000", {stall, bus.dmem_req, bus.dmem_we, wb_valid});
    end
    vectors++;
    if ({bus.dmem_addr, bus.dmem_wdata, wb_data} !== 96'h0) begin
      errors++; $display("FAIL reset_data: addr=%h wdata=%h wb_data=%h, required zero", bus.dmem_addr, bus.dmem_wdata, wb_data);
    end
    vectors++;
    if ({bus.dmem_be, wb_rd} !== 9'h0) begin
      errors++; $display("FAIL reset_be_rd: be=%b wb_rd=%0d, required 0000/0", bus.dmem_be, wb_rd);
    end
    @(negedge clk);
    ex_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_alu();
    @(negedge clk);
    opcode = OP_ALU; alu_result = 32'h55; rd_in = 5'd7; ex_valid = 1'b1;
    exp_q.push_back({32'h55, 5'd7});
    #1 vectors++;
    if (stall !== 1'b0) begin errors++; $display("FAIL alu_stall: stall=%b, required 0", stall); end
    @(negedge clk);
    ex_valid = 1'b0;
    vectors++;
    if ({stall, wb_valid, wb_data} !== {1'b0, 1'b1, 32'h55}) begin
      errors++; $display("FAIL alu_latency: stall=%b wb_valid=%b wb_data=%h, required 0/1/00000055", stall, wb_valid, wb_data);
    end
    @(negedge clk);
    vectors++;
    if ({stall, wb_valid} !== 2'b00) begin
      errors++; $display("FAIL alu_idle: stall=%b wb_valid=%b, required 0/0", stall, wb_valid);
    end
  endtask

  task automatic test_no_start();
    @(negedge clk);
    opcode = OPCODE_LOAD; func3 = F3_W; alu_result = 32'h80; rd_in = 5'd3; ex_valid = 1'b0;
    #1 vectors++;
    if (stall !== 1'b0) begin errors++; $display("FAIL nostart_stall: stall=%b, required 0", stall); end
    @(negedge clk);
    vectors++;
    if ({bus.dmem_req, wb_valid} !== 2'b00) begin
      errors++; $display("FAIL nostart_req: req=%b wb_valid=%b, required 0/0", bus.dmem_req, wb_valid);
    end
  endtask

  task automatic test_store();
    logic [31:0] a, w; logic [3:0] be; logic we, st; int ns;
    mem_op(OPCODE_STORE, F3_W, 32'h100, 32'hDEADBEEF, 5'd0, 2, 0, 32'h0, a, w, be, we, ns, st);
    vectors++;
    if ({a, w, be, we, st} !== {32'h100, 32'hDEADBEEF, 4'b1111, 1'b1, 1'b1}) begin
      errors++; $display("FAIL sw_bus: addr=%h wdata=%h be=%b we=%b stable=%b, required 00000100/deadbeef/1111/1/1", a, w, be, we, st);
    end
    vectors++;
    if (ns != 3) begin errors++; $display("FAIL sw_stall_cycles: got %0d, required 3", ns); end
    mem_op(OPCODE_STORE, F3_H, 32'h202, 32'h0000ABCD, 5'd0, 1, 0, 32'h0, a, w, be, we, ns, st);
    vectors++;
    if ({a, w, be, we} !== {32'h200, 32'hABCDABCD, 4'b1100, 1'b1}) begin
      errors++; $display("FAIL sh_bus: addr=%h wdata=%h be=%b we=%b, required 00000200/abcdabcd/1100/1", a, w, be, we);
    end
    mem_op(OPCODE_STORE, F3_B, 32'h101, 32'h0000005A, 5'd0, 3, 0, 32'h0, a, w, be, we, ns, st);
    vectors++;
    if ({a, w, be, st} !== {32'h100, 32'h5A5A5A5A, 4'b0010, 1'b1}) begin
      errors++; $display("FAIL sb_bus: addr=%h wdata=%h be=%b stable=%b, required 00000100/5a5a5a5a/0010/1", a, w, be, st);
    end
  endtask

  task automatic test_load();
    logic [31:0] a, w; logic [3:0] be; logic we, st; int ns;
    exp_q.push_back({32'hFFFFFF80, 5'd9});
    mem_op(OPCODE_LOAD, F3_B, 32'h103, 32'h0, 5'd9, 1, 2, 32'h80000000, a, w, be, we, ns, st);
    vectors++;
    if ({a, be, we, ns} !== {32'h100, 4'b1000, 1'b0, 32'd4}) begin
      errors++; $display("FAIL lb_bus: addr=%h be=%b we=%b stalls=%0d, required 00000100/1000/0/4", a, be, we, ns);
    end
    exp_q.push_back({32'h00000080, 5'd10});
    mem_op(OPCODE_LOAD, F3_BU, 32'h103, 32'h0, 5'd10, 2, 1, 32'h80000000, a, w, be, we, ns, st);
    exp_q.push_back({32'h12345678, 5'd17});
    mem_op(OPCODE_LOAD, F3_W, 32'h400, 32'h0, 5'd17, 1, 0, 32'h12345678, a, w, be, we, ns, st);
    vectors++;
    if ({wb_valid, wb_rd, ns} !== {1'b1, 5'd17, 32'd2}) begin
      errors++; $display("FAIL lw_same_cycle: wb_valid=%b wb_rd=%0d stalls=%0d, required 1/17/2", wb_valid, wb_rd, ns);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, w; logic [3:0] be; logic we, st; int ns;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      opcode = OP_ALU; alu_result = 32'h1000 + 32'(i) * 32'h111; rd_in = 5'(i + 1); ex_valid = 1'b1;
      exp_q.push_back({32'h1000 + 32'(i) * 32'h111, 5'(i + 1)});
      @(negedge clk);
    end
    ex_valid = 1'b0;
    exp_q.push_back({32'hFFFF8001, 5'd20});
    mem_op(OPCODE_LOAD, F3_H, 32'h402, 32'h0, 5'd20, 1, 1, 32'h80010000, a, w, be, we, ns, st);
    exp_q.push_back({32'h00008001, 5'd21});
    mem_op(OPCODE_LOAD, F3_HU, 32'h402, 32'h0, 5'd21, 1, 0, 32'h80010000, a, w, be, we, ns, st);
    vectors++;
    if (be !== 4'b1100) begin errors++; $display("FAIL lhu_be: be=%b, required 1100", be); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    opcode = OPCODE_LOAD; func3 = F3_W; alu_result = 32'h300; rd_in = 5'd5; ex_valid = 1'b1;
    @(negedge clk);
    bus.dmem_gnt = 1'b1;
    @(negedge clk);
    bus.dmem_gnt = 1'b0;
    vectors++;
    if (stall !== 1'b1) begin errors++; $display("FAIL wait_stall: stall=%b, required 1", stall); end
    rst_n = 1'b0;
    ex_valid = 1'b0;
    #1 vectors++;
    if ({stall, bus.dmem_req, wb_valid} !== 3'b000) begin
      errors++; $display("FAIL midreset: stall/req/wb=%b, required 000", {stall, bus.dmem_req, wb_valid});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    bus.dmem_rvalid = 1'b0;
    vectors++;
    if ({stall, bus.dmem_req, wb_valid} !== 3'b000) begin
      errors++; $display("FAIL late_rvalid: stall/req/wb=%b, required 000", {stall, bus.dmem_req, wb_valid});
    end
  endtask

  task automatic test_misalign();
`ifdef MISALIGN_TRAP_EN
    @(negedge clk);
    opcode = OPCODE_LOAD; func3 = F3_W; alu_result = 32'h101; rd_in = 5'd4; ex_valid = 1'b1;
    #1 vectors++;
    if (stall !== 1'b0) begin errors++; $display("FAIL trap_stall: stall=%b, required 0", stall); end
    @(negedge clk);
    ex_valid = 1'b0;
    vectors++;
    if ({misalign_exc, bus.dmem_req} !== 2'b10) begin
      errors++; $display("FAIL trap_pulse: exc=%b req=%b, required 1/0", misalign_exc, bus.dmem_req);
    end
    @(negedge clk);
    vectors++;
    if ({misalign_exc, bus.dmem_req, wb_valid} !== 3'b000) begin
      errors++; $display("FAIL trap_end: exc/req/wb=%b, required 000", {misalign_exc, bus.dmem_req, wb_valid});
    end
`else
    logic [31:0] a, w; logic [3:0] be; logic we, st; int ns;
    exp_q.push_back({32'h11223344, 5'd4});
    mem_op(OPCODE_LOAD, F3_W, 32'h101, 32'h0, 5'd4, 1, 0, 32'h11223344, a, w, be, we, ns, st);
    vectors++;
    if ({a, be} !== {32'h100, 4'b1111}) begin
      errors++; $display("FAIL lw_misalign: addr=%h be=%b, required 00000100/1111", a, be);
    end
    mem_op(OPCODE_STORE, F3_H, 32'h203, 32'h00001234, 5'd0, 1, 0, 32'h0, a, w, be, we, ns, st);
    vectors++;
    if ({a, w, be} !== {32'h200, 32'h12341234, 4'b1100}) begin
      errors++; $display("FAIL sh_misalign: addr=%h wdata=%h be=%b, required 00000200/12341234/1100", a, w, be);
    end
`endif
  endtask

  initial begin
    bus.dmem_gnt = 1'b0;
    bus.dmem_rvalid = 1'b0;
    bus.dmem_rdata = '0;
    test_reset();
    test_alu();
    test_no_start();
    test_store();
    test_load();
    test_back_to_back();
    test_reset_mid();
    test_misalign();
    repeat (2) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL wb_missing: %0d writebacks outstanding, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: ex_valid  input  1  execute-stage outputs valid this cycle.
REQ-004 SHALL have port: opcode  input  7  instruction opcode from execute.
REQ-005 SHALL have port: func3  input  3  access width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-006 SHALL have port: alu_result  input  32  execute result; byte address for loads and stores.
REQ-007 SHALL have port: store_data  input  32  selected op2 from execute; unshifted store data.
REQ-008 SHALL have port: rd_in  input  5  destination register.
REQ-009 SHALL have port: stall  output  1  freeze upstream stages; execute inputs held stable while high.
REQ-010 SHALL have ports: dmem_req, dmem_we  output  1 each  memory request and write strobe.
REQ-011 SHALL have ports: dmem_addr  output  32 (word-aligned); dmem_wdata  output  32; dmem_be  output  4.
REQ-012 SHALL have ports: dmem_gnt, dmem_rvalid  input  1 each; dmem_rdata  input  32.
REQ-013 SHALL have ports: wb_valid  output  1; wb_data  output  32; wb_rd  output  5.

Function
REQ-014 SHALL implement FSM states IDLE, REQ, WAIT, DONE.
REQ-015 Non-memory op with ex_valid in IDLE SHALL give wb_valid=1, wb_data=alu_result, wb_rd=rd_in next cycle (latency 1, no stall).
REQ-016 Load/store with ex_valid in IDLE SHALL latch address, data, func3, rd and move to REQ; stall SHALL assert combinationally that cycle.
REQ-017 In REQ, dmem_req SHALL stay high with stable addr/wdata/be/we until the cycle dmem_gnt=1.
REQ-018 Store at gnt SHALL go to DONE; load at gnt SHALL go to WAIT, or to DONE if dmem_rvalid is also high that cycle.
REQ-019 In WAIT, dmem_rvalid=1 SHALL capture the extracted load data and go to DONE.
REQ-020 DONE SHALL last one cycle with stall=0; load asserts wb_valid, store does not; next state IDLE.
REQ-021 stall SHALL be high in REQ and WAIT and low in IDLE (except per REQ-016) and DONE.
REQ-022 Byte enables: B 0001<<addr[1:0], H 0011<<addr[1:0], W 1111; wdata replicated per lane.
REQ-023 Load extract SHALL shift by addr[1:0]; B/H sign-extend, BU/HU zero-extend.
REQ-024 ex_valid=0 or stall=1 SHALL NOT start a new access; wb_valid SHALL be 0 in any cycle with no completion.

Reset
REQ-025 rst_n low SHALL force IDLE and stall, dmem_req, dmem_we, wb_valid low; dmem_addr, dmem_wdata, wb_data zero; dmem_be 0000; wb_rd 0.
REQ-026 Reset during REQ or WAIT SHALL abandon the access; a late dmem_rvalid after reset SHALL be ignored in IDLE.

Configuration
REQ-027 With MISALIGN_TRAP_EN defined, misaligned H (addr[0]=1) or W (addr[1:0]!=0) SHALL issue no request, assert output misalign_exc for one cycle and return to IDLE.
REQ-028 Without MISALIGN_TRAP_EN, port misalign_exc SHALL be absent and misaligned accesses SHALL use addr with low bits forced to zero.

Structure
REQ-029 A shared package SHALL hold OPCODE_LOAD (0000011), OPCODE_STORE (0100011), func3 width constants and the FSM state typedef.
REQ-030 Sub-module lsu_align SHALL hold the combinational byte-enable/wdata shift and load extract/extend logic.

Verification
REQ-031 SW addr 0x100, data 0xDEADBEEF, gnt after 2 cycles -> be 1111, wdata 0xDEADBEEF, stall for 3 cycles, no wb_valid.
REQ-032 LB addr 0x103, rdata 0x80000000 -> wb_data 0xFFFFFF80; LBU same -> 0x00000080.
REQ-033 SH addr 0x202, data 0x0000ABCD -> dmem_addr 0x200, be 1100, wdata 0xABCDABCD.
REQ-034 LW with gnt and rvalid in same cycle, rdata 0x12345678 -> wb_valid next cycle, wb_data 0x12345678, rd preserved.
REQ-035 ADD result 0x55 with ex_valid -> wb_data 0x55 one cycle later, stall never high.
REQ-036 rst_n low mid-WAIT, then rvalid pulse -> IDLE, wb_valid 0; with MISALIGN_TRAP_EN, LW addr 0x101 -> misalign_exc pulse, no dmem_req.
